// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared MMIO constants for the MIPS data-memory responder
package mips_mem_pkg;

    typedef enum logic [1:0] {
        MMIO_CYCLE  = 2'd0,
        MMIO_TOHOST = 2'd1,
        MMIO_STATUS = 2'd2,
        MMIO_RSVD   = 2'd3
    } mmio_off_e;

    localparam int STAT_OVERFLOW_BIT = 31;
    localparam int STAT_FULL_BIT     = 30;
    localparam int STAT_EMPTY_BIT    = 29;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_FFF0;

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - synchronous word FIFO with wrap-around pointers and a count register
module word_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_data,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty;
    // A push into a full FIFO is taken only when the head leaves on the same edge.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MIPS data-memory responder: word RAM plus cycle/tohost MMIO window
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH      = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);

    localparam int RAM_AW = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       r_ram [DEPTH];
    logic [31:0]       r_cycle;
    logic              r_overflow;

    logic              w_mmio_sel;
    mmio_off_e         w_off;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_push_req;
    logic              w_pop;
    logic              w_status_wr;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [31:0]       w_status;
    logic              w_unused;

    assign w_mmio_sel  = (addr[31:4] == MMIO_BASE[31:4]);
    assign w_off       = mmio_off_e'(addr[3:2]);
    assign w_ram_idx   = addr[RAM_AW+1:2];
    assign w_push_req  = memwrite & w_mmio_sel & (w_off == MMIO_TOHOST);
    assign w_status_wr = memwrite & w_mmio_sel & (w_off == MMIO_STATUS);
    assign w_pop       = out_valid & out_ready;
    assign out_valid   = ~w_empty;
    assign overflow    = r_overflow;
    assign w_unused    = &{1'b0, addr[1:0]};

    word_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tohost_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_data  (writedata),
        .o_head  (out_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_status                    = '0;
        w_status[STAT_OVERFLOW_BIT] = r_overflow;
        w_status[STAT_FULL_BIT]     = w_full;
        w_status[STAT_EMPTY_BIT]    = w_empty;
        w_status[CNT_W-1:0]         = w_count;
    end

    always_comb begin
        readdata = '0;
        if (w_mmio_sel) begin
            unique case (w_off)
                MMIO_CYCLE:  readdata = r_cycle;
                MMIO_STATUS: readdata = w_status;
                default:     readdata = '0;
            endcase
        end else begin
            readdata = r_ram[w_ram_idx];
        end
    end

    // RAM is deliberately outside the reset domain so it survives a mid-run reset.
    always_ff @(posedge clk) begin
        if (memwrite && !w_mmio_sel) begin
            r_ram[w_ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_status_wr) begin
                r_overflow <= 1'b0;
            end else if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
